// File: rtl/ram_pack_pkg.sv
// rtl/ram_pack_pkg.sv - shared types and width helpers for the RAM byte-packing engine
//
// Purpose: one-hot FSM state encoding, default geometry constants and the
//          address-width helper used by ram_pack_fsm and its RAMs.
// Ports:   none (package).

package ram_pack_pkg;

  // One-hot state encoding
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_READ   = 4'b0010,
    ST_WRITE  = 4'b0100,
    ST_FINISH = 4'b1000
  } state_e;

  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_PACK      = 2;
  localparam int DEF_IN_DEPTH  = 32;
  localparam int DEF_OUT_DEPTH = DEF_IN_DEPTH / DEF_PACK;

  // Address width for a given depth; never returns 0 so degenerate
  // single-entry memories still get a legal 1-bit address.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_dp_async_read.sv
// rtl/ram_dp_async_read.sv - dual-port RAM, synchronous write, asynchronous read
//
// Purpose: simple-dual-port storage; write on clk rising edge, combinational
//          read. A write becomes visible on the read port after the edge.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   addr_wr  in   write address
//   data_wr  in   write data
//   addr_rd  in   read address
//   data_rd  out  read data (combinational from addr_rd)

module ram_dp_async_read
  import ram_pack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr_wr,
  input  logic [WIDTH-1:0] data_wr,
  input  logic [AW-1:0]    addr_rd,
  output logic [WIDTH-1:0] data_rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_wr] <= data_wr;
    end
  end

  assign data_rd = mem[addr_rd];

endmodule

// File: rtl/ram_pack_fsm.sv
// rtl/ram_pack_fsm.sv - packs PACK input RAM entries per output RAM word
//
// Purpose: host fills the input RAM; on an accepted start the FSM reads PACK
//          consecutive entries per word, assembles them LSB- or MSB-first and
//          writes len words into the output RAM. Optional running XOR
//          checksum of captured entries when RAM_PACK_CKSUM_EN is defined.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ram_in_we        host write enable, input RAM
//   ram_in_addr_wr   host write address, input RAM
//   ram_in_data_wr   host write data, input RAM
//   ram_out_addr_rd  host read address, output RAM
//   ram_out_data_rd  output RAM read data (combinational)
//   start            single-cycle run request
//   len              words to produce (1..OUT_DEPTH), sampled on accepted start
//   msb_first        byte order, sampled on accepted start
//   busy             run in progress
//   done             one-cycle pulse at run end
//   error            one-cycle pulse after a rejected start
//   checksum         XOR of captured entries (RAM_PACK_CKSUM_EN only)

module ram_pack_fsm
  import ram_pack_pkg::*;
#(
  parameter  int IN_WIDTH  = DEF_IN_WIDTH,
  parameter  int PACK      = DEF_PACK,
  parameter  int IN_DEPTH  = DEF_IN_DEPTH,
  localparam int OUT_DEPTH = IN_DEPTH / PACK,
  localparam int AI        = addr_bits(IN_DEPTH),
  localparam int AO        = addr_bits(OUT_DEPTH),
  localparam int OW        = PACK * IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ram_in_we,
  input  logic [AI-1:0]       ram_in_addr_wr,
  input  logic [IN_WIDTH-1:0] ram_in_data_wr,
  input  logic [AO-1:0]       ram_out_addr_rd,
  output logic [OW-1:0]       ram_out_data_rd,
  input  logic                start,
  input  logic [AO:0]         len,
  input  logic                msb_first,
  output logic                busy,
  output logic                done,
  output logic                error
`ifdef RAM_PACK_CKSUM_EN
  ,
  output logic [IN_WIDTH-1:0] checksum
`endif
);

  localparam int            BW          = addr_bits(PACK);
  localparam logic [BW-1:0] PACK_LAST   = BW'(PACK - 1);
  localparam logic [AO:0]   OUT_DEPTH_L = (AO + 1)'(OUT_DEPTH);
  localparam logic [AO:0]   LEN_ONE     = (AO + 1)'(1);

  state_e        state_q, state_d;
  logic [AI-1:0] rd_ptr_q, rd_ptr_d;
  logic [AO-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [AO:0]   len_q, len_d;
  logic          msb_q, msb_d;
  logic [OW-1:0] asm_q, asm_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
`ifdef RAM_PACK_CKSUM_EN
  logic [IN_WIDTH-1:0] cksum_q, cksum_d;
`endif

  logic [IN_WIDTH-1:0] in_rd_data;
  logic                len_ok;
  logic                last_word;
  int                  sel;

  ram_dp_async_read #(
    .WIDTH (IN_WIDTH),
    .DEPTH (IN_DEPTH)
  ) u_ram_in (
    .clk     (clk),
    .we      (ram_in_we),
    .addr_wr (ram_in_addr_wr),
    .data_wr (ram_in_data_wr),
    .addr_rd (rd_ptr_q),
    .data_rd (in_rd_data)
  );

  ram_dp_async_read #(
    .WIDTH (OW),
    .DEPTH (OUT_DEPTH)
  ) u_ram_out (
    .clk     (clk),
    .we      (state_q == ST_WRITE),
    .addr_wr (wr_ptr_q),
    .data_wr (asm_q),
    .addr_rd (ram_out_addr_rd),
    .data_rd (ram_out_data_rd)
  );

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    msb_d      = msb_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
`ifdef RAM_PACK_CKSUM_EN
    cksum_d    = cksum_q;
`endif

    len_ok    = (len != '0) && (len <= OUT_DEPTH_L);
    last_word = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));
    // Slot of the current entry inside the assembled word
    sel       = msb_q ? (PACK - 1 - int'(byte_cnt_q)) : int'(byte_cnt_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d      = len;
            msb_d      = msb_first;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
`ifdef RAM_PACK_CKSUM_EN
            cksum_d    = '0;
`endif
            state_d    = ST_READ;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        for (int k = 0; k < PACK; k++) begin
          if (k == sel) begin
            asm_d[k*IN_WIDTH +: IN_WIDTH] = in_rd_data;
          end
        end
`ifdef RAM_PACK_CKSUM_EN
        cksum_d    = cksum_q ^ in_rd_data;
`endif
        rd_ptr_d   = rd_ptr_q + AI'(1);
        byte_cnt_d = byte_cnt_q + BW'(1);
        if (byte_cnt_q == PACK_LAST) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The output RAM write itself is driven from state_q this cycle
        if (last_word) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wr_ptr_d   = wr_ptr_q + AO'(1);
          byte_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      asm_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef RAM_PACK_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      msb_q      <= msb_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef RAM_PACK_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;
`ifdef RAM_PACK_CKSUM_EN
  assign checksum = cksum_q;
`endif

endmodule

// File: tb/tb_ram_pack_fsm.sv
// tb/tb_ram_pack_fsm.sv - self-checking bench for ram_pack_fsm (default and PACK=4 builds)

module tb_ram_pack_fsm;

  localparam int W   = 8;
  localparam int P   = 2;
  localparam int D   = 32;
  localparam int OD  = 16;
  localparam int P4  = 4;
  localparam int D4  = 16;
  localparam int OD4 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         we;
  logic [4:0]   waddr;
  logic [7:0]   wdata;
  logic [3:0]   raddr;
  logic [15:0]  rdata;
  logic         start;
  logic [4:0]   len;
  logic         msb;
  logic         busy, done, error;

  logic         we4;
  logic [3:0]   waddr4;
  logic [7:0]   wdata4;
  logic [1:0]   raddr4;
  logic [31:0]  rdata4;
  logic         start4;
  logic [2:0]   len4;
  logic         msb4;
  logic         busy4, done4, error4;
`ifdef RAM_PACK_CKSUM_EN
  logic [7:0]   cksum;
  logic [7:0]   cksum4;
`endif

  ram_pack_fsm #(.IN_WIDTH(W), .PACK(P), .IN_DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_in_we       (we),
    .ram_in_addr_wr  (waddr),
    .ram_in_data_wr  (wdata),
    .ram_out_addr_rd (raddr),
    .ram_out_data_rd (rdata),
    .start           (start),
    .len             (len),
    .msb_first       (msb),
    .busy            (busy),
    .done            (done),
    .error           (error)
`ifdef RAM_PACK_CKSUM_EN
    ,
    .checksum        (cksum)
`endif
  );

  ram_pack_fsm #(.IN_WIDTH(W), .PACK(P4), .IN_DEPTH(D4)) dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_in_we       (we4),
    .ram_in_addr_wr  (waddr4),
    .ram_in_data_wr  (wdata4),
    .ram_out_addr_rd (raddr4),
    .ram_out_data_rd (rdata4),
    .start           (start4),
    .len             (len4),
    .msb_first       (msb4),
    .busy            (busy4),
    .done            (done4),
    .error           (error4)
`ifdef RAM_PACK_CKSUM_EN
    ,
    .checksum        (cksum4)
`endif
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp4_t;

  exp_t        sb[$];
  exp4_t       sb4[$];
  logic [7:0]  in_m [D];
  logic [15:0] out_m [OD];
  logic [7:0]  in4_m [D4];

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus helpers: all called and returning at a falling edge
  task automatic write_in(input logic [4:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    in_m[a] = d;
  endtask

  task automatic write_in4(input logic [3:0] a, input logic [7:0] d);
    we4 = 1'b1; waddr4 = a; wdata4 = d;
    @(negedge clk);
    we4 = 1'b0;
    in4_m[a] = d;
  endtask

  // Update the output RAM model for a run and queue every word for readback
  task automatic push_run(input logic [4:0] l, input logic m);
    logic [15:0] wd;
    int s;
    for (int w = 0; w < int'(l); w++) begin
      wd = '0;
      for (int k = 0; k < P; k++) begin
        s = m ? (P - 1 - k) : k;
        wd[s*W +: W] = in_m[w*P + k];
      end
      out_m[w] = wd;
    end
    for (int a = 0; a < OD; a++) begin
      sb.push_back('{a, out_m[a]});
    end
  endtask

  // Returns in cycle 1 (start was high in cycle 0)
  task automatic pulse_start(input logic [4:0] l, input logic m);
    start = 1'b1; len = l; msb = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from cycle 1 until done, bounded
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    we = 0; waddr = '0; wdata = '0; raddr = '0; start = 0; len = '0; msb = 0;
    we4 = 0; waddr4 = '0; wdata4 = '0; raddr4 = '0; start4 = 0; len4 = '0; msb4 = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
`ifdef RAM_PACK_CKSUM_EN
    n_checks++; if (cksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum: got %h expected 00", cksum); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lsb_default;
    int cyc;
    exp_t e;
    for (int i = 0; i < D; i++) write_in(5'(i), 8'(i));
    push_run(5'd16, 1'b0);
    pulse_start(5'd16, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lsb_busy_c1: got %b expected 1", busy); end
    wait_done(cyc);
    n_checks++; if (cyc != 49) begin n_fail++; $display("FAIL lsb_done_cycle: got %0d expected 49", cyc); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lsb_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.addr[3:0]; #1;
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL lsb_out[%0d]: got %h expected %h", e.addr, rdata, e.data); end
    end
    raddr = 4'd0; #1;
    n_checks++; if (rdata !== 16'h0100) begin n_fail++; $display("FAIL lsb_out0_lit: got %h expected 0100", rdata); end
    raddr = 4'd15; #1;
    n_checks++; if (rdata !== 16'h1F1E) begin n_fail++; $display("FAIL lsb_out15_lit: got %h expected 1f1e", rdata); end
    @(negedge clk);
  endtask

  task automatic test_msb_first;
    int cyc;
    exp_t e;
    push_run(5'd4, 1'b1);
    pulse_start(5'd4, 1'b1);
    wait_done(cyc);
    n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL msb_done_cycle: got %0d expected 13", cyc); end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.addr[3:0]; #1;
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL msb_out[%0d]: got %h expected %h", e.addr, rdata, e.data); end
    end
    raddr = 4'd0; #1;
    n_checks++; if (rdata !== 16'h0001) begin n_fail++; $display("FAIL msb_out0_lit: got %h expected 0001", rdata); end
    raddr = 4'd3; #1;
    n_checks++; if (rdata !== 16'h0607) begin n_fail++; $display("FAIL msb_out3_lit: got %h expected 0607", rdata); end
    @(negedge clk);
  endtask

  task automatic test_pack4;
    int cyc;
    exp4_t e;
    logic [31:0] wd;
    for (int i = 0; i < D4; i++) write_in4(4'(i), 8'hA0 + 8'(i));
    for (int w = 0; w < OD4; w++) begin
      wd = '0;
      for (int k = 0; k < P4; k++) wd[k*W +: W] = in4_m[w*P4 + k];
      sb4.push_back('{w, wd});
    end
    start4 = 1'b1; len4 = 3'd4; msb4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 21) begin n_fail++; $display("FAIL pack4_done_cycle: got %0d expected 21", cyc); end
    @(negedge clk);
    while (sb4.size() > 0) begin
      e = sb4.pop_front();
      raddr4 = e.addr[1:0]; #1;
      n_checks++; if (rdata4 !== e.data) begin n_fail++; $display("FAIL pack4_out[%0d]: got %h expected %h", e.addr, rdata4, e.data); end
    end
    raddr4 = 2'd1; #1;
    n_checks++; if (rdata4 !== 32'hA7A6A5A4) begin n_fail++; $display("FAIL pack4_out1_lit: got %h expected a7a6a5a4", rdata4); end
    @(negedge clk);
  endtask

  task automatic test_len_error;
    logic [4:0] bad [2];
    exp_t e;
    bad[0] = 5'd0;
    bad[1] = 5'd17;
    for (int t = 0; t < 2; t++) begin
      pulse_start(bad[t], 1'b0);
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_pulse_len%0d: got %b expected 1", bad[t], error); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy_len%0d: got %b expected 0", bad[t], busy); end
      @(negedge clk);
      n_checks++; if (error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_clear_len%0d: got error=%b busy=%b expected 0 0", bad[t], error, busy); end
    end
    for (int a = 0; a < OD; a++) sb.push_back('{a, out_m[a]});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.addr[3:0]; #1;
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL err_untouched[%0d]: got %h expected %h", e.addr, rdata, e.data); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cnt;
    int dcyc;
    exp_t e;
    for (int i = 0; i < D; i++) write_in(5'(i), 8'(i) ^ 8'h5A);
    pulse_start(5'd16, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_run(5'd16, 1'b0);
    pulse_start(5'd16, 1'b0);
    cnt = 0;
    dcyc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin cnt++; dcyc = c; end
      if (c == 5) begin start = 1'b1; len = 5'd2; msb = 1'b1; end
      if (c == 6) begin
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL midrst_ignore_start: got busy=%b error=%b expected 1 0", busy, error); end
      end
      @(negedge clk);
    end
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL midrst_done_count: got %0d expected 1", cnt); end
    n_checks++; if (dcyc != 49) begin n_fail++; $display("FAIL midrst_done_cycle: got %0d expected 49", dcyc); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.addr[3:0]; #1;
      n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL midrst_out[%0d]: got %h expected %h", e.addr, rdata, e.data); end
    end
    @(negedge clk);
  endtask

`ifdef RAM_PACK_CKSUM_EN
  task automatic test_checksum;
    int cyc;
    logic [7:0] x;
    logic [7:0] lit [2];
    lit[0] = 8'h00;
    lit[1] = 8'hFA;
    for (int i = 0; i < D; i++) write_in(5'(i), 8'(i));
    for (int t = 0; t < 2; t++) begin
      if (t == 1) write_in(5'd5, 8'hFF);
      x = '0;
      for (int i = 0; i < D; i++) x ^= in_m[i];
      pulse_start(5'd16, 1'b0);
      wait_done(cyc);
      n_checks++; if (cksum !== x) begin n_fail++; $display("FAIL cksum_model_%0d: got %h expected %h", t, cksum, x); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (cksum !== lit[t]) begin n_fail++; $display("FAIL cksum_hold_%0d: got %h expected %h", t, cksum, lit[t]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_default();
    test_msb_first();
    test_pack4();
    test_len_error();
    test_reset_mid_run();
`ifdef RAM_PACK_CKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
